// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER memory-mapped I/O peripherals.
// Contents:
//   - base addresses of the OTTER I/O map
//   - timer register offsets (word index within the 16-byte window)
//   - CTRL/STATUS bit positions
//   - timer effective-state enum and a helper that derives it from CTRL
package otter_io_pkg;

  localparam logic [31:0] IO_BASE_ADDR  = 32'h1100_0000;
  localparam logic [31:0] TMR_BASE_ADDR = 32'h1100_0200;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_COUNT  = 2'd1;
  localparam logic [1:0] TMR_CMP    = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_AUTO_BIT   = 1;
  localparam int CTRL_IE_BIT     = 2;
  localparam int CTRL_PRE_LSB    = 8;
  localparam int STATUS_PEND_BIT = 0;

  typedef enum logic [1:0] {
    TS_IDLE        = 2'd0,
    TS_RUN_ONESHOT = 2'd1,
    TS_RUN_AUTO    = 2'd2
  } timer_state_e;

  function automatic timer_state_e timer_state(input logic en, input logic auto_rl);
    if (!en)     return TS_IDLE;
    if (auto_rl) return TS_RUN_AUTO;
    return TS_RUN_ONESHOT;
  endfunction

endpackage

// File: rtl/otter_timer_intc_if.sv
// OTTER I/O bus slice seen by one peripheral.
// Signals:
//   iobus_wr   - store strobe, one cycle per store
//   iobus_addr - byte address
//   iobus_out  - store data
//   rd_data    - read data, zero when the address misses this peripheral
//   rd_hit     - address falls inside this peripheral's window
// Transfer rule: there is no ready/stall. A store completes at the clock
// edge where iobus_wr=1 and the address hits; a read is a purely
// combinational function of iobus_addr and current register state.
interface otter_timer_intc_if;
  logic        iobus_wr;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic [31:0] rd_data;
  logic        rd_hit;

  modport master (output iobus_wr, iobus_addr, iobus_out, input rd_data, rd_hit);
  modport slave  (input iobus_wr, iobus_addr, iobus_out, output rd_data, rd_hit);
endinterface

// File: rtl/otter_prescaler.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick when the
// count equals limit, then wraps to 0. limit=0 ticks every enabled cycle.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   en         - advance the count (count holds when low)
//   clr        - synchronous clear, wins over en
//   limit      - terminal count
//   tick       - asserted in the cycle the count equals limit while en=1
module otter_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] limit,
  output logic             tick
);

  logic [PRE_W-1:0] cnt_q;

  assign tick = en && (cnt_q == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/otter_timer_intc.sv
// OTTER timer / interrupt source.
// Four word registers in a 16-byte window at BASE_ADDR:
//   0x0 CTRL   [0] EN, [1] AUTO, [2] IE, [8+:PRE_W] PRESCALE
//   0x4 COUNT  prescaled up-counter
//   0x8 CMP    compare value
//   0xC STATUS [0] PEND, write 1 to clear
// Ports:
//   clk, RST_n - clock, async active-low reset
//   bus        - I/O bus slice (store decode, combinational read return)
//   intr       - level interrupt, PEND & IE
//   state      - effective timer state (IDLE / RUN_ONESHOT / RUN_AUTO)
module otter_timer_intc
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TMR_BASE_ADDR,
  parameter int          CNT_W     = 32,
  parameter int          PRE_W     = 8
) (
  input  logic                 clk,
  input  logic                 RST_n,
  otter_timer_intc_if.slave    bus,
  output logic                 intr,
  output timer_state_e         state
);

  logic             hit;
  logic [1:0]       off;
  logic             wr_ctrl, wr_count, wr_cmp, wr_status;
  logic             tick, match;

  logic             en_q, auto_q, ie_q, pend_q;
  logic [PRE_W-1:0] pre_lim_q;
  logic [CNT_W-1:0] count_q, cmp_q;

  logic             en_d, auto_d, ie_d, pend_d;
  logic [PRE_W-1:0] pre_lim_d;
  logic [CNT_W-1:0] count_d, cmp_d;

  logic [31:0]      rd;
  logic             unused_bits;

  assign unused_bits = ^bus.iobus_addr[1:0];

  assign hit       = (bus.iobus_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = bus.iobus_addr[3:2];
  assign wr_ctrl   = bus.iobus_wr && hit && (off == TMR_CTRL);
  assign wr_count  = bus.iobus_wr && hit && (off == TMR_COUNT);
  assign wr_cmp    = bus.iobus_wr && hit && (off == TMR_CMP);
  assign wr_status = bus.iobus_wr && hit && (off == TMR_STATUS);

  // tick is derived from the pre-write EN, so a CTRL write in a tick cycle
  // still lets that edge be processed with the old EN/AUTO.
  otter_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk   (clk),
    .rst_n (RST_n),
    .en    (en_q),
    .clr   (wr_ctrl),
    .limit (pre_lim_q),
    .tick  (tick)
  );

  // A COUNT store overrides the tick entirely, including match detection.
  assign match = tick && !wr_count && (count_q == cmp_q);

  // State register
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ie_q      <= 1'b0;
      pre_lim_q <= '0;
      count_q   <= '0;
      cmp_q     <= '1;
      pend_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      auto_q    <= auto_d;
      ie_q      <= ie_d;
      pre_lim_q <= pre_lim_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state logic; later assignments carry higher priority.
  always_comb begin
    en_d      = en_q;
    auto_d    = auto_q;
    ie_d      = ie_q;
    pre_lim_d = pre_lim_q;
    count_d   = count_q;
    cmp_d     = cmp_q;
    pend_d    = pend_q;

    if (tick && !wr_count) begin
      if (match) begin
        if (auto_q) count_d = '0;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    if (wr_count) count_d = bus.iobus_out[CNT_W-1:0];
    if (wr_cmp)   cmp_d   = bus.iobus_out[CNT_W-1:0];
    if (wr_ctrl) begin
      en_d      = bus.iobus_out[CTRL_EN_BIT];
      auto_d    = bus.iobus_out[CTRL_AUTO_BIT];
      ie_d      = bus.iobus_out[CTRL_IE_BIT];
      pre_lim_d = bus.iobus_out[CTRL_PRE_LSB +: PRE_W];
    end

    if (wr_status && bus.iobus_out[STATUS_PEND_BIT]) pend_d = 1'b0;
    if (match) pend_d = 1'b1;  // set beats a simultaneous clear
  end

  // Outputs
  always_comb begin
    rd = '0;
    case (off)
      TMR_CTRL: begin
        rd[CTRL_EN_BIT]                = en_q;
        rd[CTRL_AUTO_BIT]              = auto_q;
        rd[CTRL_IE_BIT]                = ie_q;
        rd[CTRL_PRE_LSB +: PRE_W]      = pre_lim_q;
      end
      TMR_COUNT:  rd[CNT_W-1:0]        = count_q;
      TMR_CMP:    rd[CNT_W-1:0]        = cmp_q;
      TMR_STATUS: rd[STATUS_PEND_BIT]  = pend_q;
      default:    rd                   = '0;
    endcase
    if (!hit) rd = '0;  // zero on miss so it can be OR-merged with other peripherals

    bus.rd_data = rd;
    bus.rd_hit  = hit;
    intr        = pend_q && ie_q;
    state       = timer_state(en_q, auto_q);
  end

endmodule

// File: tb/tb_otter_timer_intc.sv
module tb_otter_timer_intc;
  import otter_io_pkg::*;

  localparam logic [31:0] A_CTRL = 32'h1100_0200;
  localparam logic [31:0] A_CNT  = 32'h1100_0204;
  localparam logic [31:0] A_CMP  = 32'h1100_0208;
  localparam logic [31:0] A_STAT = 32'h1100_020C;
  localparam logic [31:0] A_OUT  = 32'h1100_0300;

  localparam int K_RD    = 0;
  localparam int K_HIT   = 1;
  localparam int K_INTR  = 2;
  localparam int K_STATE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RST_n = 1'b0;
  always #5 clk = ~clk;

  otter_timer_intc_if bus ();
  otter_timer_intc_if bus8 ();
  logic intr, intr8;
  timer_state_e state, state8;

  otter_timer_intc u_dut (
    .clk(clk), .RST_n(RST_n), .bus(bus), .intr(intr), .state(state)
  );

  otter_timer_intc #(.CNT_W(8)) u_dut8 (
    .clk(clk), .RST_n(RST_n), .bus(bus8), .intr(intr8), .state(state8)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          kind_q[$];
  bit          sel_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, act;
      int          k;
      bit          s;
      string       n;
      e = exp_q.pop_front();
      k = kind_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      case (k)
        K_RD:    act = s ? bus8.rd_data : bus.rd_data;
        K_HIT:   act = {31'b0, (s ? bus8.rd_hit : bus.rd_hit)};
        K_INTR:  act = {31'b0, (s ? intr8 : intr)};
        default: act = {30'b0, (s ? state8 : state)};
      endcase
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input bit s8, input int kind, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    kind_q.push_back(kind);
    sel_q.push_back(s8);
    name_q.push_back(name);
  endtask

  task automatic bus_wr(input bit s8, input logic [31:0] addr, input logic [31:0] data);
    if (s8) begin
      bus8.iobus_wr = 1'b1; bus8.iobus_addr = addr; bus8.iobus_out = data;
    end else begin
      bus.iobus_wr = 1'b1; bus.iobus_addr = addr; bus.iobus_out = data;
    end
    @(posedge clk);
    #1;
    bus.iobus_wr  = 1'b0;
    bus8.iobus_wr = 1'b0;
  endtask

  task automatic rd_chk(input bit s8, input logic [31:0] addr, input logic [31:0] exp, input string name);
    if (s8) bus8.iobus_addr = addr;
    else    bus.iobus_addr  = addr;
    expect_now(s8, K_RD, exp, name);
    step(1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.iobus_wr = 1'b0;  bus.iobus_addr = 32'h0;  bus.iobus_out = 32'h0;
    bus8.iobus_wr = 1'b0; bus8.iobus_addr = 32'h0; bus8.iobus_out = 32'h0;
    step(3);
    RST_n = 1'b1;
    step(1);

    // reset values and decode
    expect_now(0, K_INTR, 32'd0, "reset_intr");
    expect_now(0, K_STATE, 32'(TS_IDLE), "reset_state");
    rd_chk(0, A_CTRL, 32'h0, "reset_ctrl");
    rd_chk(0, A_CNT, 32'h0, "reset_count");
    expect_now(0, K_HIT, 32'd1, "hit_in_window");
    rd_chk(0, A_CMP, 32'hFFFF_FFFF, "reset_cmp");
    rd_chk(0, A_STAT, 32'h0, "reset_status");
    rd_chk(1, A_CMP, 32'h0000_00FF, "reset_cmp8_zero_fill");
    expect_now(0, K_HIT, 32'd0, "miss_hit");
    rd_chk(0, A_OUT, 32'h0, "miss_rd_data");

    // one-shot: CMP=3, PRESCALE=0
    bus_wr(0, A_CMP, 32'd3);
    bus_wr(0, A_CTRL, 32'h5);
    expect_now(0, K_INTR, 32'd0, "os_intr_c0");
    rd_chk(0, A_CNT, 32'd0, "os_count_c0");
    rd_chk(0, A_CNT, 32'd1, "os_count_c1");
    rd_chk(0, A_CNT, 32'd2, "os_count_c2");
    expect_now(0, K_INTR, 32'd0, "os_intr_c3");
    rd_chk(0, A_CNT, 32'd3, "os_count_c3");
    expect_now(0, K_INTR, 32'd1, "os_intr_c4");
    expect_now(0, K_STATE, 32'(TS_IDLE), "os_state_stop");
    rd_chk(0, A_STAT, 32'd1, "os_pend");
    rd_chk(0, A_CTRL, 32'h4, "os_ctrl_en_cleared");
    step(3);
    rd_chk(0, A_CNT, 32'd3, "os_count_holds");
    bus_wr(0, A_STAT, 32'd1);
    expect_now(0, K_INTR, 32'd0, "os_intr_cleared");

    // auto-reload: CMP=2, PRESCALE=3 -> match every 12 cycles
    bus_wr(0, A_CMP, 32'd2);
    bus_wr(0, A_CNT, 32'd0);
    bus_wr(0, A_CTRL, 32'h307);
    expect_now(0, K_STATE, 32'(TS_RUN_AUTO), "ar_state");
    step(5);
    rd_chk(0, A_CNT, 32'd1, "ar_count_c5");
    step(3);
    rd_chk(0, A_CNT, 32'd2, "ar_count_c9");
    expect_now(0, K_INTR, 32'd0, "ar_intr_c10");
    step(1);
    expect_now(0, K_INTR, 32'd0, "ar_intr_c11");
    step(1);
    expect_now(0, K_INTR, 32'd1, "ar_intr_c12");
    rd_chk(0, A_CNT, 32'd0, "ar_count_reload");
    bus_wr(0, A_STAT, 32'd1);
    expect_now(0, K_INTR, 32'd0, "ar_intr_cleared");
    step(9);
    expect_now(0, K_INTR, 32'd0, "ar_intr_c23");
    step(1);
    expect_now(0, K_INTR, 32'd1, "ar_intr_c24");
    step(1);

    // clear/set collision at the c36 match edge
    bus_wr(0, A_STAT, 32'd1);
    expect_now(0, K_INTR, 32'd0, "col_intr_pre");
    step(9);
    bus_wr(0, A_STAT, 32'd1);
    expect_now(0, K_INTR, 32'd1, "col_set_wins_intr");
    rd_chk(0, A_STAT, 32'd1, "col_set_wins_pend");
    rd_chk(0, A_CNT, 32'd0, "col_count");

    // COUNT write on a matching tick edge
    bus_wr(0, A_CTRL, 32'h0);
    bus_wr(0, A_CMP, 32'd7);
    bus_wr(0, A_STAT, 32'd1);
    bus_wr(0, A_CNT, 32'd6);
    bus_wr(0, A_CTRL, 32'h5);
    step(1);
    bus_wr(0, A_CNT, 32'd7);
    expect_now(0, K_INTR, 32'd0, "cw_no_match_intr");
    rd_chk(0, A_STAT, 32'd0, "cw_no_match_pend");
    expect_now(0, K_INTR, 32'd1, "cw_next_tick_intr");
    rd_chk(0, A_CNT, 32'd7, "cw_count");

    // 8-bit counter wrap
    bus_wr(1, A_CMP, 32'h05);
    bus_wr(1, A_CNT, 32'hFE);
    bus_wr(1, A_CTRL, 32'h5);
    rd_chk(1, A_CNT, 32'h0000_00FE, "wr_count_fe");
    rd_chk(1, A_CNT, 32'h0000_00FF, "wr_count_ff");
    expect_now(1, K_INTR, 32'd0, "wr_intr_at_wrap");
    rd_chk(1, A_CNT, 32'h0000_0000, "wr_count_00");
    step(4);
    expect_now(1, K_INTR, 32'd0, "wr_intr_c7");
    rd_chk(1, A_CNT, 32'h0000_0005, "wr_count_05");
    expect_now(1, K_INTR, 32'd1, "wr_intr_match");
    rd_chk(1, A_STAT, 32'd1, "wr_pend");

    // async reset mid-count with COUNT=5, EN=1, intr high
    bus_wr(0, A_CNT, 32'd0);
    bus_wr(0, A_CMP, 32'd100);
    bus_wr(0, A_CTRL, 32'h5);
    step(5);
    expect_now(0, K_INTR, 32'd1, "rst_intr_before");
    rd_chk(0, A_CNT, 32'd5, "rst_count_before");
    RST_n = 1'b0;
    expect_now(0, K_INTR, 32'd0, "rst_intr_same_cycle");
    expect_now(1, K_INTR, 32'd0, "rst_intr8_same_cycle");
    rd_chk(0, A_CNT, 32'd0, "rst_count");
    rd_chk(0, A_CTRL, 32'h0, "rst_ctrl");
    rd_chk(0, A_STAT, 32'h0, "rst_pend");
    rd_chk(0, A_CMP, 32'hFFFF_FFFF, "rst_cmp");
    RST_n = 1'b1;
    step(2);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
